// File: rtl/stoch_mult_sequencer.sv
// Job controller for the bipolar stochastic multiplier datapath: seeds the
// LFSRs, enables N=2^L cycles of SN generation and counts the returned bits.
module stoch_mult_sequencer #(
  parameter int unsigned PW      = 4,
  parameter int unsigned MAX_LOG = 8,
  parameter int unsigned MIN_LOG = 3,
  parameter int unsigned LFSR_W  = 31,
  parameter logic [LFSR_W-1:0] SEED_A = LFSR_W'(1),
  parameter logic [LFSR_W-1:0] SEED_B = LFSR_W'(2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_prob_a,
  input  logic [PW-1:0]        in_prob_b,
  input  logic [3:0]           in_log_len,
  input  logic                 abort,
  output logic                 dp_seed_load,
  output logic [LFSR_W-1:0]    dp_seed_a,
  output logic [LFSR_W-1:0]    dp_seed_b,
  output logic [PW-1:0]        dp_prob_a,
  output logic [PW-1:0]        dp_prob_b,
  output logic                 dp_en,
  input  logic                 dp_sn_valid,
  input  logic                 dp_sn_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_LOG:0]     out_ones,
  output logic [MAX_LOG+1:0]   out_bipolar,
  output logic                 busy
);

  localparam int unsigned CW = MAX_LOG + 1;
  localparam int unsigned BW = MAX_LOG + 2;

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       n_q, issue_q, recv_q, ones_q;
  logic [CW-1:0]       n_d, issue_d, recv_d, ones_d;
  logic [BW-1:0]       bipolar_d;
  logic                en_q;
  logic [PW-1:0]       prob_a_q, prob_b_q;
  logic [LFSR_W-1:0]   seed_a_q, seed_b_q;
  logic [CW-1:0]       out_ones_q;
  logic [BW-1:0]       out_bipolar_q;
  int unsigned         len_u, l_clamp;

  always_comb begin
    len_u = 32'(in_log_len);
    if (len_u < MIN_LOG)      l_clamp = MIN_LOG;
    else if (len_u > MAX_LOG) l_clamp = MAX_LOG;
    else                      l_clamp = len_u;
    n_d       = CW'(1) << l_clamp;
    issue_d   = issue_q + CW'(1);
    recv_d    = recv_q + CW'(1);
    ones_d    = ones_q + CW'(dp_sn_bit);
    // Modular BW-bit arithmetic; the true result always fits in -N..+N.
    bipolar_d = (BW'(ones_d) << 1) - BW'(n_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      n_q           <= '0;
      issue_q       <= '0;
      recv_q        <= '0;
      ones_q        <= '0;
      en_q          <= 1'b0;
      prob_a_q      <= '0;
      prob_b_q      <= '0;
      seed_a_q      <= '0;
      seed_b_q      <= '0;
      out_ones_q    <= '0;
      out_bipolar_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            prob_a_q <= in_prob_a;
            prob_b_q <= in_prob_b;
            n_q      <= n_d;
            issue_q  <= '0;
            recv_q   <= '0;
            ones_q   <= '0;
            seed_a_q <= SEED_A;
            seed_b_q <= SEED_B;
            state_q  <= SEED;
          end
        end
        SEED: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            en_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (en_q) begin
              issue_q <= issue_d;
              if (issue_d == n_q) en_q <= 1'b0;
            end
            if (dp_sn_valid && (recv_q < n_q)) begin
              recv_q <= recv_d;
              ones_q <= ones_d;
              if (recv_d == n_q) begin
                en_q          <= 1'b0;
                out_ones_q    <= ones_d;
                out_bipolar_q <= bipolar_d;
                state_q       <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (abort || out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // abort gates the enable combinationally so the datapath stops that cycle.
  assign dp_en        = en_q & ~abort;
  assign in_ready     = (state_q == IDLE);
  assign dp_seed_load = (state_q == SEED);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign dp_seed_a    = seed_a_q;
  assign dp_seed_b    = seed_b_q;
  assign dp_prob_a    = prob_a_q;
  assign dp_prob_b    = prob_b_q;
  assign out_ones     = out_ones_q;
  assign out_bipolar  = out_bipolar_q;

endmodule

// File: tb/tb_stoch_mult_sequencer.sv
// Bench for stoch_mult_sequencer with a latency-2 datapath stub and a
// result scoreboard.
module tb_stoch_mult_sequencer;

  localparam int unsigned PW      = 4;
  localparam int unsigned MAX_LOG = 8;
  localparam int unsigned LFSR_W  = 31;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [PW-1:0]       in_prob_a, in_prob_b;
  logic [3:0]          in_log_len;
  logic                abort;
  logic                dp_seed_load;
  logic [LFSR_W-1:0]   dp_seed_a, dp_seed_b;
  logic [PW-1:0]       dp_prob_a, dp_prob_b;
  logic                dp_en;
  logic                dp_sn_valid, dp_sn_bit;
  logic                out_valid;
  logic                out_ready;
  logic [MAX_LOG:0]    out_ones;
  logic [MAX_LOG+1:0]  out_bipolar;
  logic                busy;

  stoch_mult_sequencer #(
    .PW(PW), .MAX_LOG(MAX_LOG), .MIN_LOG(3), .LFSR_W(LFSR_W),
    .SEED_A(31'd1), .SEED_B(31'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prob_a(in_prob_a), .in_prob_b(in_prob_b), .in_log_len(in_log_len),
    .abort(abort),
    .dp_seed_load(dp_seed_load), .dp_seed_a(dp_seed_a), .dp_seed_b(dp_seed_b),
    .dp_prob_a(dp_prob_a), .dp_prob_b(dp_prob_b), .dp_en(dp_en),
    .dp_sn_valid(dp_sn_valid), .dp_sn_bit(dp_sn_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ones(out_ones), .out_bipolar(out_bipolar), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stub: mode 0 all ones, 1 all zeros, 2 alternating starting with 1.
  int          mode;
  int unsigned iss_n;
  logic [1:0]  vpipe, bpipe;
  logic        stub_bit;

  always_comb begin
    stub_bit = 1'b1;
    if (mode == 1)      stub_bit = 1'b0;
    else if (mode == 2) stub_bit = ~iss_n[0];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      bpipe <= '0;
      iss_n <= 0;
    end else begin
      if (dp_seed_load) iss_n <= 0;
      else if (dp_en)   iss_n <= iss_n + 1;
      vpipe <= {vpipe[0], dp_en};
      bpipe <= {bpipe[0], stub_bit};
    end
  end
  assign dp_sn_valid = vpipe[1];
  assign dp_sn_bit   = bpipe[1];

  int cyc = 0;
  int en_cnt = 0, sl_cnt = 0, ov_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dp_en)        en_cnt <= en_cnt + 1;
    if (dp_seed_load) sl_cnt <= sl_cnt + 1;
    if (out_valid)    ov_cnt <= ov_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int ones;
    int bip;
  } res_t;
  res_t sb_q[$];

  typedef struct {
    logic [3:0] len;
    int         md;
    int         n;
    int         ones;
    int         bip;
  } vec_t;
  vec_t vecs[7];

  task automatic run_job(input logic [3:0] len, input int md, input int exp_n,
                         input int exp_ones, input int exp_bip, input int hold);
    int c_acc, en0, sl0, waited;
    logic [PW-1:0] pa, pb;
    res_t r;
    mode = md;
    pa = PW'($urandom_range(0, 15));
    pb = PW'($urandom_range(0, 15));
    sb_q.push_back('{exp_ones, exp_bip});
    @(posedge clk); #1;
    check("in_ready before job", longint'(in_ready), 1);
    in_valid = 1'b1; in_prob_a = pa; in_prob_b = pb; in_log_len = len;
    out_ready = (hold == 0);
    en0 = en_cnt; sl0 = sl_cnt;
    @(posedge clk); #1;
    c_acc = cyc;
    in_valid = 1'b0; in_prob_a = ~pa; in_prob_b = ~pb;
    in_log_len = 4'($urandom_range(0, 15));
    @(negedge clk);
    check("seed_load", longint'(dp_seed_load), 1);
    check("seed_a", longint'(dp_seed_a), 1);
    check("seed_b", longint'(dp_seed_b), 2);
    waited = 0;
    while (!out_valid && waited < 600) begin
      @(negedge clk);
      waited++;
      if (dp_en) begin
        check("prob_a held", longint'(dp_prob_a), longint'(pa));
        check("prob_b held", longint'(dp_prob_b), longint'(pb));
      end
    end
    if (!out_valid) begin
      check("out_valid timeout", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    check("latency", longint'(cyc - c_acc + 1), longint'(exp_n + 4));
    check("dp_en cycles", longint'(en_cnt - en0), longint'(exp_n));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(negedge clk);
      check("hold out_valid", longint'(out_valid), 1);
      check("hold out_ones", longint'(out_ones), longint'(exp_ones));
      check("hold in_ready", longint'(in_ready), 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 0, 1);
    end else begin
      r = sb_q.pop_front();
      check("out_ones", longint'(out_ones), longint'(r.ones));
      check("out_bipolar", longint'($signed(out_bipolar)), longint'(r.bip));
    end
    @(posedge clk); #1;
    check("seed loads", longint'(sl_cnt - sl0), 1);
    @(negedge clk);
    check("in_ready after", longint'(in_ready), 1);
    check("out_valid after", longint'(out_valid), 0);
  endtask

  int en0, ov0;

  initial begin
    vecs[0] = '{4'd3,  0, 8,   8,   8};
    vecs[1] = '{4'd4,  1, 16,  0,   -16};
    vecs[2] = '{4'd5,  2, 32,  16,  0};
    vecs[3] = '{4'd1,  0, 8,   8,   8};
    vecs[4] = '{4'd12, 0, 256, 256, 256};
    vecs[5] = '{4'd8,  2, 256, 128, 0};
    vecs[6] = '{4'd6,  1, 64,  0,   -64};

    rst_n = 1'b0; in_valid = 1'b0; in_prob_a = '0; in_prob_b = '0;
    in_log_len = '0; abort = 1'b0; out_ready = 1'b1; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst dp_en", longint'(dp_en), 0);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst seed_load", longint'(dp_seed_load), 0);
    check("rst busy", longint'(busy), 0);
    check("rst out_ones", longint'(out_ones), 0);
    check("rst out_bipolar", longint'(out_bipolar), 0);
    check("rst seed_a", longint'(dp_seed_a), 0);
    check("rst prob_a", longint'(dp_prob_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", longint'(in_ready), 1);

    for (int v = 0; v < 7; v++)
      run_job(vecs[v].len, vecs[v].md, vecs[v].n, vecs[v].ones, vecs[v].bip, 0);

    // Backpressure in DONE, then a following job.
    run_job(4'd3, 0, 8, 8, 8, 20);
    run_job(4'd3, 2, 8, 4, 0, 0);

    // Abort on the third dp_en cycle.
    mode = 0;
    ov0 = ov_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_log_len = 4'd3;
    en0 = en_cnt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-abort dp_en", longint'(dp_en), 1);
    abort = 1'b1;
    @(negedge clk);
    check("abort dp_en", longint'(dp_en), 0);
    check("abort en count", longint'(en_cnt - en0), 2);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort busy", longint'(busy), 0);
    check("abort in_ready", longint'(in_ready), 1);
    run_job(4'd3, 0, 8, 8, 8, 0);
    check("abort out_valid count", longint'(ov_cnt - ov0), 1);

    // Reset pulse mid-RUN.
    mode = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_log_len = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset dp_en", longint'(dp_en), 1);
    rst_n = 1'b0;
    #1;
    check("reset dp_en", longint'(dp_en), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset busy", longint'(busy), 0);
    ov0 = ov_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready post reset", longint'(in_ready), 1);
    repeat (30) @(negedge clk);
    check("no out_valid after reset", longint'(ov_cnt - ov0), 0);
    run_job(4'd4, 0, 16, 16, 16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_mult_sequencer.md
Name: stoch_mult_sequencer

Overview:
Job-level controller for the bipolar stochastic multiplier datapath (two LFSRs, two comparators, XNOR stage). It accepts one operand pair per job over a valid/ready handshake and seeds the datapath. It then enables the datapath for a configurable power-of-two stream length and counts the returned SN bits. The result goes out as a ones-count plus a signed bipolar value, with no count overflow. It sits between the tile's I/O/config logic and the datapath, and is the only block driving the datapath's seed and enable controls.

Parameters:
PW, 4, probability operand width per input
MAX_LOG, 8, maximum log2 stream length; count width is MAX_LOG+1
MIN_LOG, 3, minimum log2 stream length
LFSR_W, 31, datapath LFSR width
SEED_A, 31'd1, seed driven for LFSR A
SEED_B, 31'd2, seed driven for LFSR B

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job request
in_ready  out  1  controller can accept a job
in_prob_a  in  PW  operand A probability
in_prob_b  in  PW  operand B probability
in_log_len  in  4  log2 stream length for this job
abort  in  1  synchronous job cancel
dp_seed_load  out  1  one-cycle seed load strobe
dp_seed_a  out  LFSR_W  seed for LFSR A
dp_seed_b  out  LFSR_W  seed for LFSR B
dp_prob_a  out  PW  latched operand A
dp_prob_b  out  PW  latched operand B
dp_en  out  1  datapath advance, one SN bit requested per cycle
dp_sn_valid  in  1  datapath returns a bit (fixed unknown latency after dp_en)
dp_sn_bit  in  1  XNOR product bit
out_valid  out  1  result available
out_ready  in  1  result consumed
out_ones  out  MAX_LOG+1  number of 1s in stream, 0..N
out_bipolar  out  MAX_LOG+2  signed 2*out_ones - N
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE.
  - All counters 0.
  - dp_seed_load, dp_en and out_valid are 0.
  - out_ones, out_bipolar, dp_prob_a/b and dp_seed_a/b are 0.
  - in_ready=1 once reset is released.
- Stream length: N = 2^L, where L = clamp(in_log_len, MIN_LOG, MAX_LOG), latched on accept.
- FSM states: IDLE, SEED, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch probs and L, clear issue_cnt/recv_cnt/ones_cnt, go to SEED.
  - dp_sn_valid is ignored (flush of stale bits).
- SEED:
  - dp_seed_load=1 for exactly one cycle, with dp_seed_a=SEED_A and dp_seed_b=SEED_B.
  - Next state RUN.
- RUN:
  - dp_en=1 while issue_cnt<N; issue_cnt increments per enabled cycle. dp_en deasserts after exactly N cycles.
  - Each dp_sn_valid increments recv_cnt and adds dp_sn_bit to ones_cnt.
  - Go to DONE on the cycle recv_cnt reaches N, counting the current return.
  - Returns beyond N are ignored.
- DONE:
  - out_valid=1.
  - out_ones and out_bipolar are registered on entry and held stable until out_valid&out_ready.
  - On out_valid&out_ready, go to IDLE; in_ready rises the next cycle.
- Arithmetic:
  - ones_cnt is MAX_LOG+1 bits, so ones_cnt=N is representable.
  - out_bipolar = (ones<<1) - N, two's complement, range -N..+N.
- Latency: accept at cycle 0, seed load at cycle 1, dp_en on cycles 2..N+1. out_valid is asserted one cycle after the Nth return.
- abort:
  - In SEED or RUN: dp_en drops the same cycle and state goes to IDLE, with no result.
  - In DONE: the result is dropped and state goes to IDLE.
  - In IDLE: no effect.
  - abort has priority over all other transitions.
- Simultaneous events: in_valid is ignored outside IDLE (in_ready=0). An operand change during RUN does not affect the latched dp_prob_a/b.
- Reset mid-job: all state clears immediately; no out_valid is produced.

Test Plan:
- Datapath stub with latency 2 returning all 1s; prob_a=prob_b=15, in_log_len=3 -> dp_en high exactly 8 cycles, out_ones=8, out_bipolar=+8, out_valid at cycle 12 after accept.
- Stub returning all 0s, in_log_len=4 -> out_ones=0, out_bipolar=-16; stub alternating 1/0, in_log_len=5 -> out_ones=16, out_bipolar=0.
- in_log_len=1 -> clamped to 8 dp_en cycles; in_log_len=12 with MAX_LOG=8 -> 256 dp_en cycles, all-1s stub gives out_ones=256 with no wrap.
- out_ready held low 20 cycles in DONE -> out_valid and result held stable, in_ready=0, a second in_valid is not accepted; releasing out_ready -> IDLE, next job accepted.
- abort asserted on the 3rd dp_en cycle -> dp_en low the same cycle, no out_valid. Late stub returns arriving in IDLE are not counted in the next job, whose all-1s count of 8 is exact.
- rst_n pulsed low mid-RUN -> dp_en, out_valid and busy go 0 asynchronously; in_ready=1 after release; dp_seed_load is seen exactly once per job.
